// File: rtl/mac_tx_frame_builder_if.sv
// Upstream payload stream and downstream frame stream of the MAC TX frame builder.
// The builder attaches through the slave modport; the payload source/frame sink uses master.
interface mac_tx_frame_builder_if;
   logic [7:0]  up_tdata_in;
   logic        up_tvalid_in;
   logic        up_tready_out;
   logic        up_tlast_in;
   logic [1:0]  up_ttype_in;
   logic [47:0] up_dst_mac_in;
   logic [7:0]  mac_tdata_out;
   logic        mac_tvalid_out;
   logic        mac_tready_in;
   logic        mac_tlast_out;
   logic        frame_err_out;

   modport slave (
      input  up_tdata_in, up_tvalid_in, up_tlast_in, up_ttype_in, up_dst_mac_in, mac_tready_in,
      output up_tready_out, mac_tdata_out, mac_tvalid_out, mac_tlast_out, frame_err_out
   );

   modport master (
      output up_tdata_in, up_tvalid_in, up_tlast_in, up_ttype_in, up_dst_mac_in, mac_tready_in,
      input  up_tready_out, mac_tdata_out, mac_tvalid_out, mac_tlast_out, frame_err_out
   );
endinterface

// File: rtl/mac_tx_frame_builder.sv
// Builds Ethernet frames (dst MAC, src MAC, ethertype, payload, zero pad to 46 bytes)
// from an upstream byte stream; FCS is appended further down the transmit path.
module mac_tx_frame_builder #(
   parameter logic [47:0] LOCAL_MAC   = 48'hABCD_1234_5678,
   parameter int unsigned MAX_PAYLOAD = 1500
) (
   input logic                   logic_clk,
   input logic                   logic_rst,
   mac_tx_frame_builder_if.slave bus
);

   localparam int unsigned MIN_PAYLOAD = 46;

   typedef enum logic [2:0] {StIdle, StHeader, StPayload, StPad, StDrop} state_e;

   state_e      state_q;
   logic [3:0]  hdr_idx_q;
   logic [10:0] cnt_q;
   logic [47:0] dst_mac_q;
   logic [15:0] eth_type_q;
   logic        frame_err_q;

   logic [15:0]  eth_type_sel;
   logic [111:0] hdr_bits;
   logic [3:0]   hdr_rev;
   logic [7:0]   hdr_byte;
   logic         pay_last;
   logic         pay_max;
   logic         pay_acc;

   always_comb begin
      unique case (bus.up_ttype_in)
         2'b00:   eth_type_sel = 16'h0800;
         2'b01:   eth_type_sel = 16'h0806;
         2'b10:   eth_type_sel = 16'h86DD;
         default: eth_type_sel = 16'h0000;
      endcase
   end

   // Header is read MSB-first out of one flat vector, indexed by byte position.
   assign hdr_bits = {dst_mac_q, LOCAL_MAC, eth_type_q};
   assign hdr_rev  = 4'd13 - hdr_idx_q;
   assign hdr_byte = hdr_bits[{hdr_rev, 3'b000} +: 8];

   // cnt_q holds bytes already accepted, so the byte on the bus is number cnt_q + 1.
   assign pay_last = bus.up_tlast_in && (cnt_q >= 11'(MIN_PAYLOAD - 1));
   assign pay_max  = (cnt_q == 11'(MAX_PAYLOAD - 1));
   assign pay_acc  = bus.up_tvalid_in && bus.mac_tready_in;

   always_comb begin
      bus.mac_tdata_out  = 8'h00;
      bus.mac_tvalid_out = 1'b0;
      bus.mac_tlast_out  = 1'b0;
      bus.up_tready_out  = 1'b0;
      unique case (state_q)
         StHeader: begin
            bus.mac_tvalid_out = 1'b1;
            bus.mac_tdata_out  = hdr_byte;
         end
         StPayload: begin
            bus.mac_tdata_out  = bus.up_tdata_in;
            bus.mac_tvalid_out = bus.up_tvalid_in;
            bus.up_tready_out  = bus.mac_tready_in;
            bus.mac_tlast_out  = bus.up_tvalid_in && (pay_last || pay_max);
         end
         StPad: begin
            bus.mac_tvalid_out = 1'b1;
            bus.mac_tlast_out  = (cnt_q == 11'(MIN_PAYLOAD - 1));
         end
         StDrop:  bus.up_tready_out = 1'b1;
         default: ;
      endcase
   end

   assign bus.frame_err_out = frame_err_q;

   always_ff @(posedge logic_clk or negedge logic_rst) begin
      if (!logic_rst) begin
         state_q     <= StIdle;
         hdr_idx_q   <= 4'd0;
         cnt_q       <= 11'd0;
         dst_mac_q   <= 48'd0;
         eth_type_q  <= 16'd0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // First payload byte stays on the bus; only its sideband is captured here.
               if (bus.up_tvalid_in) begin
                  dst_mac_q  <= bus.up_dst_mac_in;
                  eth_type_q <= eth_type_sel;
                  hdr_idx_q  <= 4'd0;
                  cnt_q      <= 11'd0;
                  if (bus.up_ttype_in == 2'b11) begin
                     state_q     <= StDrop;
                     frame_err_q <= 1'b1;
                  end else begin
                     state_q <= StHeader;
                  end
               end
            end
            StHeader: begin
               if (bus.mac_tready_in) begin
                  if (hdr_idx_q == 4'd13) state_q <= StPayload;
                  else hdr_idx_q <= hdr_idx_q + 4'd1;
               end
            end
            StPayload: begin
               if (pay_acc) begin
                  cnt_q <= cnt_q + 11'd1;
                  if (bus.up_tlast_in) begin
                     state_q <= pay_last ? StIdle : StPad;
                  end else if (pay_max) begin
                     state_q     <= StDrop;
                     frame_err_q <= 1'b1;
                  end
               end
            end
            StPad: begin
               if (bus.mac_tready_in) begin
                  cnt_q <= cnt_q + 11'd1;
                  if (cnt_q == 11'(MIN_PAYLOAD - 1)) state_q <= StIdle;
               end
            end
            StDrop: begin
               if (bus.up_tvalid_in && bus.up_tlast_in) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_tx_frame_builder.sv
// Scoreboard bench for mac_tx_frame_builder: expected frame bytes are queued when a
// frame is driven and checked beat by beat as the builder emits them.
module tb_mac_tx_frame_builder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mac_tx_frame_builder_if bus ();

   mac_tx_frame_builder #(
      .LOCAL_MAC   (48'hABCD_1234_5678),
      .MAX_PAYLOAD (1500)
   ) dut (
      .logic_clk (clk),
      .logic_rst (rst_n),
      .bus       (bus)
   );

   int         n_checks   = 0;
   int         n_fail     = 0;
   int         err_pulses = 0;
   int         tlast_seen = 0;
   int         beat_no    = 0;
   bit         rand_ready = 1'b0;
   logic [8:0] exp_q[$];

   function automatic logic [7:0] pay_byte(input int i, input int seed);
      if (seed == 0) return 8'(i + 1);
      return 8'(i * 7 + seed);
   endfunction

   // Reference frame: header, payload (truncated at 1500), zero pad to 46, tlast on final byte.
   task automatic push_expected(input logic [47:0] dst, input logic [15:0] etype,
                                input int len, input int seed);
      logic [47:0] lm;
      int          n_pay;
      int          n_pad;
      lm    = 48'hABCD_1234_5678;
      n_pay = (len > 1500) ? 1500 : len;
      n_pad = (n_pay < 46) ? 46 - n_pay : 0;
      for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, dst[8*(5-k) +: 8]});
      for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, lm[8*(5-k) +: 8]});
      exp_q.push_back({1'b0, etype[15:8]});
      exp_q.push_back({1'b0, etype[7:0]});
      for (int i = 0; i < n_pay; i++)
         exp_q.push_back({(n_pad == 0) && (i == n_pay - 1), pay_byte(i, seed)});
      for (int i = 0; i < n_pad; i++) exp_q.push_back({i == n_pad - 1, 8'h00});
   endtask

   initial begin
      bus.mac_tready_in = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.mac_tready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: scoreboard pops, stall stability, tlast qualification, error pulses.
   logic       prev_stall;
   logic [7:0] prev_data;
   logic       prev_last;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.frame_err_out) err_pulses++;
         if (bus.mac_tlast_out) begin
            n_checks++;
            if (bus.mac_tvalid_out !== 1'b1) begin
               n_fail++;
               $display("FAIL tlast_needs_valid: valid=%b required 1", bus.mac_tvalid_out);
            end
         end
         if (prev_stall) begin
            n_checks++;
            if ({bus.mac_tvalid_out, bus.mac_tlast_out, bus.mac_tdata_out} !==
                {1'b1, prev_last, prev_data}) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%b l=%b d=%h required v=1 l=%b d=%h",
                        bus.mac_tvalid_out, bus.mac_tlast_out, bus.mac_tdata_out,
                        prev_last, prev_data);
            end
         end
         if (bus.mac_tvalid_out && bus.mac_tready_in) begin
            logic [8:0] e;
            n_checks++;
            if (bus.mac_tlast_out) tlast_seen++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: got l=%b d=%h required no beat",
                        bus.mac_tlast_out, bus.mac_tdata_out);
            end else begin
               e = exp_q.pop_front();
               if ({bus.mac_tlast_out, bus.mac_tdata_out} !== e) begin
                  n_fail++;
                  $display("FAIL beat %0d: got l=%b d=%h required l=%b d=%h", beat_no,
                           bus.mac_tlast_out, bus.mac_tdata_out, e[8], e[7:0]);
               end
            end
            beat_no++;
         end
         prev_stall = bus.mac_tvalid_out && !bus.mac_tready_in;
         prev_data  = bus.mac_tdata_out;
         prev_last  = bus.mac_tlast_out;
      end
   end

   // Present one payload byte and hold it until the builder accepts it (bounded).
   task automatic drive_beat(input logic [7:0] d, input logic last, output bit ok);
      int t;
      bus.up_tdata_in  = d;
      bus.up_tlast_in  = last;
      bus.up_tvalid_in = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.up_tready_out && t < 5000);
      ok = bus.up_tready_out;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [1:0] ttype, input logic [47:0] dst, input int len,
                             input int seed, output int accepted);
      bit ok;
      accepted          = 0;
      bus.up_ttype_in   = ttype;
      bus.up_dst_mac_in = dst;
      for (int i = 0; i < len; i++) begin
         drive_beat(pay_byte(i, seed), i == len - 1, ok);
         if (!ok) break;
         accepted++;
      end
      bus.up_tvalid_in = 1'b0;
      bus.up_tlast_in  = 1'b0;
      n_checks++;
      if (accepted != len) begin
         n_fail++;
         $display("FAIL upstream_accept: got %0d bytes required %0d", accepted, len);
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 10000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain: got %0d bytes outstanding required 0", name, exp_q.size());
      end
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic check_err(input string name, input int e0, input int want);
      n_checks++;
      if (err_pulses - e0 != want) begin
         n_fail++;
         $display("FAIL %s frame_err: got %0d pulses required %0d", name, err_pulses - e0, want);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      n_checks++;
      if ({bus.mac_tvalid_out, bus.mac_tlast_out, bus.mac_tdata_out, bus.up_tready_out,
           bus.frame_err_out} !== 12'h000) begin
         n_fail++;
         $display("FAIL %s outputs: got v=%b l=%b d=%h r=%b e=%b required all 0", name,
                  bus.mac_tvalid_out, bus.mac_tlast_out, bus.mac_tdata_out,
                  bus.up_tready_out, bus.frame_err_out);
      end
   endtask

   task automatic run_frame(input string name, input logic [1:0] ttype, input logic [15:0] et,
                            input logic [47:0] dst, input int len, input int seed);
      int e0;
      int acc;
      e0 = err_pulses;
      push_expected(dst, et, len, seed);
      send_frame(ttype, dst, len, seed, acc);
      wait_drain(name);
      check_err(name, e0, 0);
   endtask

   task automatic test_reset();
      #1;
      check_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs_zero("post_reset_idle");
   endtask

   task automatic test_ipv4();
      run_frame("ipv4", 2'b00, 16'h0800, 48'hFFFF_FFFF_FFFF, 20, 0);
   endtask

   task automatic test_arp();
      run_frame("arp", 2'b01, 16'h0806, 48'h0011_2233_4455, 46, 3);
   endtask

   task automatic test_ipv6_stall();
      rand_ready = 1'b1;
      run_frame("ipv6", 2'b10, 16'h86DD, 48'h3333_0000_0001, 100, 5);
      rand_ready = 1'b0;
   endtask

   task automatic test_illegal_type();
      int e0;
      int b0;
      int acc;
      e0 = err_pulses;
      b0 = beat_no;
      send_frame(2'b11, 48'h0102_0304_0506, 30, 9, acc);
      repeat (3) @(negedge clk);
      n_checks++;
      if (beat_no != b0) begin
         n_fail++;
         $display("FAIL illegal_type beats: got %0d required 0", beat_no - b0);
      end
      check_err("illegal_type", e0, 1);
      @(posedge clk);
      #1;
      run_frame("after_illegal", 2'b00, 16'h0800, 48'hFFFF_FFFF_FFFF, 20, 0);
   endtask

   task automatic test_oversize();
      int e0;
      int t0;
      int acc;
      e0 = err_pulses;
      t0 = tlast_seen;
      push_expected(48'h0A0B_0C0D_0E0F, 16'h0800, 1501, 11);
      send_frame(2'b00, 48'h0A0B_0C0D_0E0F, 1501, 11, acc);
      wait_drain("oversize");
      check_err("oversize", e0, 1);
      n_checks++;
      if (tlast_seen - t0 != 1) begin
         n_fail++;
         $display("FAIL oversize tlast: got %0d required 1", tlast_seen - t0);
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      push_expected(48'h0200_0000_0001, 16'h0806, 50, 21);
      push_expected(48'h0200_0000_0002, 16'h0800, 10, 22);
      send_frame(2'b01, 48'h0200_0000_0001, 50, 21, acc);
      send_frame(2'b00, 48'h0200_0000_0002, 10, 22, acc);
      wait_drain("back_to_back");
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int t0;
      t0 = tlast_seen;
      push_expected(48'hFFFF_FFFF_FFFF, 16'h0800, 20, 0);
      bus.up_ttype_in   = 2'b00;
      bus.up_dst_mac_in = 48'hFFFF_FFFF_FFFF;
      for (int i = 0; i < 9; i++) drive_beat(pay_byte(i, 0), 1'b0, ok);
      bus.up_tdata_in  = pay_byte(9, 0);
      bus.up_tvalid_in = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("reset_mid");
      bus.up_tvalid_in = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_checks++;
      if (tlast_seen != t0) begin
         n_fail++;
         $display("FAIL reset_mid tlast: got %0d required 0", tlast_seen - t0);
      end
      @(posedge clk);
      #1;
      run_frame("after_reset", 2'b00, 16'h0800, 48'hFFFF_FFFF_FFFF, 20, 0);
   endtask

   initial begin
      bus.up_tdata_in   = 8'h00;
      bus.up_tvalid_in  = 1'b0;
      bus.up_tlast_in   = 1'b0;
      bus.up_ttype_in   = 2'b00;
      bus.up_dst_mac_in = 48'd0;
      test_reset();
      test_ipv4();
      test_arp();
      test_ipv6_stall();
      test_illegal_type();
      test_oversize();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mac_tx_frame_builder.md
MAC_TX_FRAME_BUILDER -- requirements
Module: mac_tx_frame_builder

Interface
REQ-001 Parameter LOCAL_MAC, default 48'hABCD_1234_5678, is the source MAC inserted in every frame, most significant byte first.
REQ-002 Parameter MAX_PAYLOAD, default 1500, is the maximum payload bytes per frame.
REQ-003 logic_clk  input  1  single clock; all logic in this domain.
REQ-004 logic_rst  input  1  asynchronous assert, active-low reset.
REQ-005 up_tdata_in  input  8  upper-layer payload byte.
REQ-006 up_tvalid_in  input  1  payload byte valid.
REQ-007 up_tready_out  output  1  payload byte accepted when up_tvalid_in & up_tready_out.
REQ-008 up_tlast_in  input  1  last payload byte of frame.
REQ-009 up_ttype_in  input  2  ethertype select (00=0x0800, 01=0x0806, 10=0x86DD, 11=illegal); sampled with the first payload byte.
REQ-010 up_dst_mac_in  input  48  destination MAC; sampled with the first payload byte.
REQ-011 mac_tdata_out  output  8  frame byte toward the CRC/PHY transmit path.
REQ-012 mac_tvalid_out  output  1  frame byte valid.
REQ-013 mac_tready_in  input  1  downstream accepts byte when mac_tvalid_out & mac_tready_in.
REQ-014 mac_tlast_out  output  1  last byte of frame, excluding FCS.
REQ-015 frame_err_out  output  1  one-cycle pulse on an illegal type or oversize payload.

Function
REQ-016 The FSM shall have states IDLE, HEADER, PAYLOAD, PAD and DROP.
REQ-017 IDLE: up_tready_out=0; when up_tvalid_in=1, latch up_dst_mac_in and up_ttype_in; next state is HEADER, or DROP if the type is 11.
- The first payload byte stays on the input and is not consumed in IDLE.
REQ-018 HEADER: emit 14 bytes in order: dst MAC (6), LOCAL_MAC (6), ethertype high byte, ethertype low byte.
- 4-bit index advances only on mac_tvalid_out & mac_tready_in.
- mac_tvalid_out=1 and up_tready_out=0 throughout.
- First header byte is valid the cycle after the IDLE capture.
REQ-019 PAYLOAD: pass-through.
- mac_tdata_out=up_tdata_in, mac_tvalid_out=up_tvalid_in, up_tready_out=mac_tready_in (combinational, zero latency).
- 11-bit payload counter increments per accepted byte.
REQ-020 When the payload byte with up_tlast_in is accepted:
- count <46: mac_tlast_out=0; go to PAD.
- otherwise: mac_tlast_out=1; go to IDLE.
REQ-021 PAD: emit 0x00 bytes until payload+pad = 46; mac_tlast_out=1 on the 46th; then IDLE. up_tready_out=0.
REQ-022 Oversize: if byte MAX_PAYLOAD is accepted without up_tlast_in:
- emit it with mac_tlast_out=1 and pulse frame_err_out;
- go to DROP.
REQ-023 DROP: mac_tvalid_out=0, up_tready_out=1; discard bytes up to and including the one with up_tlast_in, then IDLE.
- Entry from an illegal type pulses frame_err_out once on entry.
- up_tlast_in on the IDLE-held first byte exits DROP after that single byte.
REQ-024 While mac_tvalid_out=1 and mac_tready_in=0, mac_tdata_out and mac_tlast_out shall hold stable.
REQ-025 A new frame shall never start before the previous mac_tlast_out byte has been accepted.
- Back-to-back frames are allowed with one IDLE cycle between them.
REQ-026 mac_tlast_out shall be asserted only together with mac_tvalid_out.

Reset
REQ-027 On logic_rst=0, the following shall be forced immediately and asynchronously:
- state=IDLE; counters and latched fields=0;
- mac_tvalid_out=0, mac_tlast_out=0, mac_tdata_out=0, up_tready_out=0, frame_err_out=0.
REQ-028 Reset mid-frame shall abort the frame without emitting mac_tlast_out; the first frame after release shall be complete and correct.

Verification
REQ-029 IPv4 frame, 20-byte payload 0x01..0x14, dst FF:FF:FF:FF:FF:FF, ready=1 -> 60 bytes:
- 6x FF, AB CD 12 34 56 78, 08 00, 01..14, 26x 00;
- tlast on byte 60 only.
REQ-030 ARP frame, 46-byte payload -> 60 bytes, ethertype 08 06, no pad, tlast on the final payload byte.
REQ-031 IPv6 frame, 100-byte payload, mac_tready_in random 50% -> 114 bytes matching the reference sequence (ethertype 86 DD); no loss or duplication; data stable during stalls.
REQ-032 Type 11 with a 30-byte payload -> no mac_tvalid_out; all 30 bytes consumed; one frame_err_out pulse; the next legal frame is correct.
REQ-033 1501-byte payload, MAX_PAYLOAD=1500 -> 1514 output bytes with tlast on byte 1514; 1 byte dropped; one frame_err_out pulse.
REQ-034 logic_rst=0 at payload byte 10 -> all outputs 0 in the same cycle, no tlast; after release, a 20-byte frame reproduces REQ-029 exactly.
